// File: rtl/fetch_queue.sv
// Instruction prefetch queue: streams words from a one-cycle-latency
// memory into a circular buffer and decodes the head entry.
module fetch_queue #(
    parameter int ADDR_W   = 10,
    parameter int INSTR_W  = 16,
    parameter int OPCODE_W = 6,
    parameter int DEPTH    = 4,
    localparam int VAL_W   = INSTR_W - OPCODE_W - 2,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch,
    input  logic [ADDR_W-1:0]   br_address,
    output logic                im_rd,
    output logic [ADDR_W-1:0]   im_address,
    input  logic [INSTR_W-1:0]  im_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [OPCODE_W-1:0] op_code,
    output logic                reg_s,
    output logic                acc_s,
    output logic [VAL_W-1:0]    val,
    output logic [CNT_W-1:0]    count
);

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_infl_addr;
    logic               r_infl;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [INSTR_W-1:0] r_instr [DEPTH];
    logic [ADDR_W-1:0]  r_epc   [DEPTH];

    logic               w_pop;
    logic               w_push;
    logic               w_room;
    logic [CNT_W:0]     w_occ;
    logic [INSTR_W-1:0] w_head_instr;

    // In-flight fetch reserves a slot so its data always has room.
    assign w_occ  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_infl};
    assign w_room = w_occ < (CNT_W+1)'(DEPTH);
    assign w_push = r_infl;

    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid & out_ready;
    assign im_rd      = reset & ~branch & (w_room | w_pop);
    assign im_address = r_pc;
    assign count      = r_count;

    assign w_head_instr = r_instr[r_head];
    assign out_pc       = r_epc[r_head];
    assign op_code      = w_head_instr[INSTR_W-1 -: OPCODE_W];
    assign reg_s        = w_head_instr[INSTR_W-OPCODE_W-1];
    assign acc_s        = w_head_instr[INSTR_W-OPCODE_W-2];
    assign val          = w_head_instr[VAL_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= '0;
            r_infl      <= 1'b0;
            r_infl_addr <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_epc[i]   <= '0;
            end
        end else if (branch) begin
            r_pc    <= br_address;
            r_infl  <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            assert (!(w_push && r_count == CNT_W'(DEPTH)));
            if (w_push) begin
                r_instr[r_tail] <= im_data;
                r_epc[r_tail]   <= r_infl_addr;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (im_rd) begin
                r_pc        <= r_pc + ADDR_W'(1);
                r_infl      <= 1'b1;
                r_infl_addr <= r_pc;
            end else begin
                r_infl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard of expected
// delivered addresses checked by an independent monitor.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch;
    logic [9:0]  br_address;
    logic        im_rd;
    logic [9:0]  im_address;
    logic [15:0] im_data = 16'h0;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_pc;
    logic [5:0]  op_code;
    logic        reg_s;
    logic        acc_s;
    logic [7:0]  val;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q [$];

    fetch_queue dut (
        .clk        (clk),
        .reset      (reset),
        .branch     (branch),
        .br_address (br_address),
        .im_rd      (im_rd),
        .im_address (im_address),
        .im_data    (im_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .op_code    (op_code),
        .reg_s      (reg_s),
        .acc_s      (acc_s),
        .val        (val),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [9:0] a);
        case (a)
            10'd0:   return 16'h040D;
            10'd1:   return 16'h280C;
            10'd2:   return 16'h2C14;
            10'd3:   return 16'h080D;
            default: return {a[5:0], a[0], a[1], a[7:0]};
        endcase
    endfunction

    always @(posedge clk)
        im_data <= im_rd ? mem_word(im_address) : 16'h0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [9:0] p;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deliver: got pc %h expected none", out_pc);
            end else begin
                p = exp_q.pop_front();
                chk("deliver", {6'h0, out_pc, op_code, reg_s, acc_s, val},
                    {6'h0, p, mem_word(p)});
            end
        end
    end

    initial begin
        reset = 1'b0; branch = 1'b0; br_address = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_im_rd", im_rd, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_head", {out_pc, op_code, reg_s, acc_s, val}, 0);

        for (int i = 0; i < 4; i++) exp_q.push_back(10'(i));
        cyc(); reset = 1'b1; @(negedge clk);
        chk("c0_im_rd", im_rd, 1);
        chk("c0_addr", im_address, 0);
        cyc(); @(negedge clk);
        chk("c1_valid", out_valid, 0);
        cyc(); @(negedge clk);
        chk("c2_valid", out_valid, 1);
        chk("c2_pc", out_pc, 0);
        chk("c2_op", op_code, 6'h01);
        chk("c2_reg_s", reg_s, 0);
        chk("c2_acc_s", acc_s, 0);
        chk("c2_val", val, 8'h0D);
        for (int i = 3; i <= 5; i++) begin
            cyc(); @(negedge clk);
            chk("stream_valid", out_valid, 1);
        end
        chk("stream_pc3", out_pc, 3);

        cyc(); out_ready = 1'b0;
        repeat (3) cyc();
        cyc(); @(negedge clk);
        chk("full_count", count, 4);
        chk("full_im_rd", im_rd, 0);
        chk("full_head", out_pc, 4);
        exp_q.push_back(10'd4);
        cyc(); out_ready = 1'b1; @(negedge clk);
        chk("full_pop_rd", im_rd, 1);
        chk("full_pop_addr", im_address, 8);
        cyc(); out_ready = 1'b0; reset = 1'b0; #1;
        chk("arst_im_rd", im_rd, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_head", {out_pc, op_code, reg_s, acc_s, val}, 0);
        cyc();
        cyc(); reset = 1'b1; @(negedge clk);
        chk("rel_im_rd", im_rd, 1);
        chk("rel_addr", im_address, 0);
        repeat (4) cyc();
        cyc(); @(negedge clk);
        chk("hold_count", count, 4);
        chk("hold_im_rd", im_rd, 0);
        chk("hold_pc", out_pc, 0);
        repeat (3) cyc();
        @(negedge clk);
        chk("hold2_count", count, 4);
        chk("hold2_pc", {out_pc, op_code}, {10'd0, 6'h01});

        for (int i = 0; i < 8; i++) exp_q.push_back(10'(i));
        for (int i = 0; i < 8; i++) begin
            cyc(); out_ready = 1'b1; @(negedge clk);
            chk("drain_valid", out_valid, 1);
            chk("drain_im_rd", im_rd, 1);
        end

        cyc(); out_ready = 1'b0; branch = 1'b1; br_address = 10'h120;
        @(negedge clk);
        chk("br_im_rd", im_rd, 0);
        chk("br_pre_count", count, 3);
        cyc(); branch = 1'b0; @(negedge clk);
        chk("br_count", count, 0);
        chk("br_valid", out_valid, 0);
        chk("br_fetch_rd", im_rd, 1);
        chk("br_fetch_addr", im_address, 10'h120);
        cyc(); @(negedge clk);
        chk("br_lat_valid", out_valid, 0);
        chk("br_addr2", im_address, 10'h121);
        exp_q.push_back(10'h120);
        exp_q.push_back(10'h121);
        exp_q.push_back(10'h122);
        cyc(); out_ready = 1'b1; @(negedge clk);
        chk("br_vis_valid", out_valid, 1);
        chk("br_vis_pc", out_pc, 10'h120);
        cyc(); @(negedge clk);
        cyc(); branch = 1'b1; br_address = 10'h200; @(negedge clk);
        chk("brpop_pc", out_pc, 10'h122);
        chk("brpop_im_rd", im_rd, 0);
        cyc(); br_address = 10'h3FF; out_ready = 1'b0; @(negedge clk);
        chk("b2b_count", count, 0);
        chk("b2b_im_rd", im_rd, 0);
        chk("b2b_valid", out_valid, 0);

        exp_q.push_back(10'h3FF);
        exp_q.push_back(10'h000);
        exp_q.push_back(10'h001);
        cyc(); branch = 1'b0; out_ready = 1'b1; @(negedge clk);
        chk("wrap_rd", im_rd, 1);
        chk("wrap_a0", im_address, 10'h3FF);
        chk("wrap_valid0", out_valid, 0);
        cyc(); @(negedge clk);
        chk("wrap_a1", im_address, 10'h000);
        cyc(); @(negedge clk);
        chk("wrap_a2", im_address, 10'h001);
        chk("wrap_pc", out_pc, 10'h3FF);
        cyc();
        cyc();
        cyc(); out_ready = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
